// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and defaults for the processor I/O port controller
package io_pkg;
    localparam int IO_DATA_W    = 16;
    localparam int IO_OUT_DEPTH = 4;

    typedef enum logic [1:0] {
        RX_INIT,
        RX_EMPTY,
        RX_IRQ,
        RX_FULL
    } rx_state_t;
endpackage

// File: rtl/io_out_fifo.sv
// rtl/io_out_fifo.sv - show-ahead FIFO buffering OUT words towards the device
module io_out_fifo #(
    parameter int  DATA_W = 16,
    parameter int  DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - OUT buffering, IN capture and interrupt generation for the processor
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int DATA_W    = IO_DATA_W,
    parameter int OUT_DEPTH = IO_OUT_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              cpu_out_data,
    input  logic                           cpu_out_en,
    output logic [DATA_W-1:0]              cpu_in_data,
    input  logic                           cpu_in_read,
    output logic                           irq,
    output logic [DATA_W-1:0]              dev_tx_data,
    output logic                           dev_tx_valid,
    input  logic                           dev_tx_ready,
    input  logic [DATA_W-1:0]              dev_rx_data,
    input  logic                           dev_rx_valid,
    output logic                           dev_rx_ready,
    output logic                           out_overflow,
    output logic [$clog2(OUT_DEPTH+1)-1:0] out_count
);
    rx_state_t state;
    rx_state_t state_nxt;
    logic      rx_latch;
    logic      fifo_full;
    logic      fifo_empty;

    io_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_out_en),
        .push_data (cpu_out_data),
        .pop       (dev_tx_valid && dev_tx_ready),
        .head_data (dev_tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (out_count),
        .overflow  (out_overflow)
    );

    assign dev_tx_valid = !fifo_empty;

    always_comb begin
        assert (!(fifo_full && fifo_empty));
    end

    // Outputs decode straight from the state register, keeping input-to-output paths out.
    assign irq          = (state == RX_IRQ);
    assign dev_rx_ready = (state == RX_EMPTY);

    always_comb begin
        state_nxt = state;
        rx_latch  = 1'b0;
        case (state)
            RX_INIT:  state_nxt = RX_EMPTY;
            RX_EMPTY: begin
                if (dev_rx_valid) begin
                    rx_latch  = 1'b1;
                    state_nxt = RX_IRQ;
                end
            end
            RX_IRQ:   state_nxt = cpu_in_read ? RX_EMPTY : RX_FULL;
            RX_FULL:  begin
                if (cpu_in_read) begin
                    state_nxt = RX_EMPTY;
                end
            end
            default:  state_nxt = RX_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RX_INIT;
            cpu_in_data <= '0;
        end else begin
            state <= state_nxt;
            if (rx_latch) begin
                cpu_in_data <= dev_rx_data;
            end
        end
    end
endmodule
